// File: rtl/equiv_check_pkg.sv
// ---------------------------------------------------------------------------
// equiv_check_pkg
// Shared definitions for the equivalence-check sequencer:
//   - eq_state_t   : sequencer FSM states
//   - DEFAULT_TAPS : Galois LFSR feedback mask used when none is given
//   - DEFAULT_SEED : LFSR seed used when none is given
// ---------------------------------------------------------------------------
package equiv_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DUT_RST = 3'd1,
        ST_RST_CMP = 3'd2,
        ST_APPLY   = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_CMP     = 3'd5,
        ST_DONE    = 3'd6
    } eq_state_t;

    localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

endpackage

// File: rtl/equiv_check_sequencer_lfsr.sv
// ---------------------------------------------------------------------------
// lfsr_galois
// Right-shifting Galois LFSR: next = (q >> 1) ^ (q[0] ? TAPS : 0).
// A zero seed would lock the register at zero, so it is replaced by 1 both
// at reset and on load.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset (loads SEED)
//   load  - load `seed` (takes priority over step)
//   seed  - run-time seed value
//   step  - advance one LFSR step
//   q     - current LFSR state
// ---------------------------------------------------------------------------
module lfsr_galois
    import equiv_check_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] RST_VAL = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] seed_fixed;

    assign q_next     = {1'b0, q[WIDTH-1:1]} ^ (q[0] ? TAPS : '0);
    assign seed_fixed = (seed == '0) ? WIDTH'(1) : seed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= seed_fixed;
        end else if (step) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/equiv_check_sequencer.sv
// ---------------------------------------------------------------------------
// equiv_check_sequencer
// Drives a shared pseudo-random stimulus bus and a DUT reset into a golden
// and a post-route instance of the same design, compares their outputs a
// fixed number of cycles after each stimulus update, and accumulates a
// saturating mismatch count with first-failure capture.
// Ports:
//   clk, rst            - clock / asynchronous active-low reset
//   start, abort        - run control (abort has priority)
//   dut_rst             - active-high reset to both DUT instances
//   stim                - registered stimulus to both DUTs
//   golden_out          - golden instance output
//   netlist_out         - post-route instance output
//   busy, done, pass    - run status; pass valid with done
//   mismatch_count      - saturating mismatch count
//   first_fail_index    - compare index of the first mismatch (0 = reset compare)
//   first_fail_golden   - golden operand at the first mismatch
//   first_fail_netlist  - netlist operand at the first mismatch
// ---------------------------------------------------------------------------
module equiv_check_sequencer
    import equiv_check_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          NUM_VECTORS = 1000,
    parameter int          SETTLE      = 2,
    parameter int          RST_CYCLES  = 2,
    parameter logic [31:0] SEED        = DEFAULT_SEED,
    parameter logic [31:0] TAPS        = DEFAULT_TAPS,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             dut_rst,
    output logic [WIDTH-1:0] stim,
    input  logic [WIDTH-1:0] golden_out,
    input  logic [WIDTH-1:0] netlist_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [31:0]      first_fail_index,
    output logic [WIDTH-1:0] first_fail_golden,
    output logic [WIDTH-1:0] first_fail_netlist
);

    eq_state_t        state_reg;
    logic [31:0]      wait_cnt_reg;     // shared by DUT_RST and SETTLE
    logic [31:0]      vec_idx_reg;      // index of the vector currently applied
    logic             fail_seen_reg;
    logic [WIDTH-1:0] lfsr_q;

    logic mism;
    logic cmp_en;
    logic more_vectors;
    logic idle_like;
    logic lfsr_load;
    logic lfsr_step;

    // Case-inequality so that X/Z bits on either bus count as a mismatch in
    // simulation; synthesises as an ordinary inequality.
    assign mism         = (golden_out !== netlist_out);
    assign idle_like    = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign cmp_en       = !abort && ((state_reg == ST_RST_CMP) || (state_reg == ST_CMP));
    assign more_vectors = (vec_idx_reg < 32'(NUM_VECTORS));

    // The LFSR runs one step ahead of `stim`: it advances on the cycle that
    // leads into APPLY, so during APPLY its state already holds the new
    // vector and `stim` simply copies it. After the last vector it is not
    // advanced, so it ends equal to the final `stim`.
    assign lfsr_load = idle_like && start && !abort;
    assign lfsr_step = !abort &&
                       ((state_reg == ST_RST_CMP) || ((state_reg == ST_CMP) && more_vectors));

    lfsr_galois #(
        .WIDTH (WIDTH),
        .TAPS  (WIDTH'(TAPS)),
        .SEED  (WIDTH'(SEED))
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (WIDTH'(SEED)),
        .step  (lfsr_step),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg          <= ST_IDLE;
            wait_cnt_reg       <= '0;
            vec_idx_reg        <= '0;
            fail_seen_reg      <= 1'b0;
            dut_rst            <= 1'b0;
            stim               <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            pass               <= 1'b0;
            mismatch_count     <= '0;
            first_fail_index   <= '0;
            first_fail_golden  <= '0;
            first_fail_netlist <= '0;
        end else begin
            // Result accumulation; only active in compare states, so it never
            // collides with the clear performed on start.
            if (cmp_en && mism) begin
                if (mismatch_count != '1) begin
                    mismatch_count <= mismatch_count + CNT_W'(1);
                end
                if (!fail_seen_reg) begin
                    fail_seen_reg      <= 1'b1;
                    first_fail_index   <= vec_idx_reg;
                    first_fail_golden  <= golden_out;
                    first_fail_netlist <= netlist_out;
                end
            end

            if (abort) begin
                // Leaves results intact; DONE keeps its status.
                if (!idle_like) begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                    dut_rst   <= 1'b0;
                end
            end else begin
                case (state_reg)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state_reg          <= ST_DUT_RST;
                            wait_cnt_reg       <= 32'(RST_CYCLES - 1);
                            vec_idx_reg        <= '0;
                            fail_seen_reg      <= 1'b0;
                            dut_rst            <= 1'b1;
                            stim               <= '0;
                            busy               <= 1'b1;
                            done               <= 1'b0;
                            pass               <= 1'b0;
                            mismatch_count     <= '0;
                            first_fail_index   <= '0;
                            first_fail_golden  <= '0;
                            first_fail_netlist <= '0;
                        end
                    end
                    ST_DUT_RST: begin
                        if (wait_cnt_reg == '0) begin
                            state_reg <= ST_RST_CMP;
                            dut_rst   <= 1'b0;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg - 32'd1;
                        end
                    end
                    ST_RST_CMP: begin
                        state_reg <= ST_APPLY;
                    end
                    ST_APPLY: begin
                        stim         <= lfsr_q;
                        vec_idx_reg  <= vec_idx_reg + 32'd1;
                        wait_cnt_reg <= 32'(SETTLE - 1);
                        state_reg    <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (wait_cnt_reg == '0) begin
                            state_reg <= ST_CMP;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg - 32'd1;
                        end
                    end
                    ST_CMP: begin
                        if (more_vectors) begin
                            state_reg <= ST_APPLY;
                        end else begin
                            state_reg <= ST_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            // Include the compare happening on this very edge.
                            pass      <= (mismatch_count == '0) && !mism;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        busy      <= 1'b0;
                        dut_rst   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/equiv_check_sequencer.md
# equiv_check_sequencer

Self-checking sequencer for post-route equivalence runs. It drives one shared stimulus bus and a DUT reset into a golden instance and a post-route netlist instance of the same design. After a programmable settle time it compares the two 32-bit output buses and accumulates a mismatch count with first-failure capture. It is the synthesizable replacement for the hand-written stimulus/compare loop, so the check runs on emulation and FPGA targets with only `pass`/`done` observed.

## Interface
- `WIDTH`, 32: stimulus and compared-output width.
- `NUM_VECTORS`, 1000: random vectors applied per run (≥1).
- `SETTLE`, 2: cycles between stimulus update and compare (≥1).
- `RST_CYCLES`, 2: cycles `dut_rst` is held high at run start (≥1).
- `SEED`, 32'h1: LFSR seed; 0 is replaced by 1.
- `TAPS`, 32'h80200003: Galois LFSR feedback mask.
- `CNT_W`, 16: mismatch-counter width (saturating).

Ports:
- `clk` in 1: sole clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin run; sampled only in IDLE or DONE.
- `abort` in 1: stop run, return to IDLE.
- `dut_rst` out 1: active-high reset to both DUT instances.
- `stim` out WIDTH: registered stimulus to both DUTs.
- `golden_out` in WIDTH: golden instance output.
- `netlist_out` in WIDTH: post-route instance output.
- `busy` out 1: run in progress.
- `done` out 1: run completed; held until next `start` or reset.
- `pass` out 1: valid with `done`; 1 iff zero mismatches.
- `mismatch_count` out CNT_W: saturating mismatch count.
- `first_fail_index` out 32: compare index of first mismatch (0 = post-reset compare, k = vector k).
- `first_fail_golden`, `first_fail_netlist` out WIDTH: operands captured at first mismatch.

## Operation
- States: IDLE, DUT_RST, RST_CMP, APPLY, SETTLE, CMP, DONE.
- IDLE/DONE + `start`: clear counters and captures, load LFSR with SEED, `stim`←0, go to DUT_RST.
- DUT_RST: `dut_rst`=1 for RST_CYCLES cycles, then RST_CMP.
- RST_CMP: `dut_rst`=0; compare (index 0); go to APPLY.
- APPLY (1 cycle): LFSR steps, next = (s>>1) ^ (s[0] ? TAPS : 0). `stim` loads the new value on the exiting edge. Vector index increments. Go to SETTLE.
- SETTLE: wait SETTLE cycles, then CMP.
- CMP (1 cycle): compare with `!==` semantics; any X/Z bit counts as a mismatch. Go to APPLY if index < NUM_VECTORS, else DONE.
- Mismatch: `mismatch_count` increments, saturating at 2^CNT_W−1. On the first mismatch only, capture index and both operands.
- DONE: `busy`=0, `done`=1, `pass`=(count==0); `stim` holds the last vector.
- `abort` while busy: next state IDLE, `dut_rst`=0. `done` is not asserted and results remain readable. `abort` takes priority over all transitions, including CMP→DONE in the same cycle.
- `start` while busy is ignored. `start` and `abort` together in IDLE: abort wins, stay IDLE.

## Timing
- Reset values:
  - state IDLE; `stim`=0, `dut_rst`=0, `busy`=0, `done`=0, `pass`=0.
  - `mismatch_count`=0; all captures 0; LFSR=SEED.
- `busy` rises on the edge after `start` is sampled and falls on entry to DONE.
- Cycles from the `start`-sampling edge to `done` high = RST_CYCLES + 1 + NUM_VECTORS·(SETTLE+2). Defaults: 4003.
- Compares occur exactly SETTLE cycles after the `stim` update.
- Asynchronous reset mid-run returns everything to reset values immediately. No partial results survive.

## Structure
- Package `equiv_check_pkg`: state enum `eq_state_t` and default TAPS/SEED constants.
- One sub-module `lfsr_galois` (WIDTH, TAPS; ports `load`, `seed`, `step`, `q`). The sequencer holds the FSM, settle counter, vector counter and result registers.

## Test plan
- Identity case: WIDTH=32, SEED=1, NUM_VECTORS=4, SETTLE=2, RST_CYCLES=2, with `netlist_out`=`golden_out`=f(`stim`) → `done` exactly 19 cycles after `start`, `pass`=1, count 0. First `stim`=32'h80200003.
- Same configuration, netlist bit 0 inverted only while vector 3 is applied → count 1, `first_fail_index`=3, captured operands differ only in bit 0, `pass`=0.
- Mismatch only during reset compare (netlist X during `dut_rst`) → `first_fail_index`=0, count 1.
- CNT_W=4, NUM_VECTORS=20, constant mismatch → count saturates at 15, `first_fail_index`=0.
- `abort` asserted in the CMP cycle of the last vector → IDLE next cycle, `done`=0. A subsequent `start` re-runs with counters cleared.
- `rst` low mid-SETTLE → all outputs at reset values in the same cycle. `start` after release behaves as in the identity case.
